// File: rtl/lt24_pkg.sv
// Shared constants, state encoding and strobe record for the LT24 bus decoder.
package lt24_pkg;

  localparam int LT24_WIDTH  = 240;
  localparam int LT24_HEIGHT = 320;

  localparam logic [7:0] CMD_COL_ADDR  = 8'h2A;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h2B;
  localparam logic [7:0] CMD_MEM_WRITE = 8'h2C;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COL_ARGS  = 3'd1,
    PAGE_ARGS = 3'd2,
    MEM_WRITE = 3'd3,
    SKIP      = 3'd4
  } lt24_state_t;

  // One decoded write cycle as seen by the parent FSM.
  typedef struct packed {
    logic        wr_event;
    logic        is_data;
    logic [15:0] word;
  } lt24_wr_t;

endpackage

// File: rtl/lt24_write_strobe.sv
// LT24 write-strobe front end: registers the bus pins once, detects the
// qualified Wr_n rising edge and holds RS/Data from the last low cycle.
// Optional LT24_TIMING_CHECK_EN builds a Wr_n low-time counter that flags
// pulses shorter than MIN_WR_LOW clocks.
module lt24_write_strobe
  import lt24_pkg::*;
#(
  parameter int MIN_WR_LOW = 2
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        rs,
  input  logic        reset_n,
  input  logic [15:0] data,
  output lt24_wr_t    wr,
  output logic        conflict,
  output logic        short_wr,
  output logic        panel_rst
);

  logic        cs_q, wr_q, wr_prev, rd_q, rs_q, rst_n_q;
  logic [15:0] data_q;
  logic        cap_rs;
  logic [15:0] cap_data;

  // Single input register stage plus previous-Wr_n for edge detection.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      wr_prev <= 1'b1;
      rd_q    <= 1'b1;
      rs_q    <= 1'b0;
      rst_n_q <= 1'b1;
      data_q  <= '0;
    end else begin
      cs_q    <= cs_n;
      wr_q    <= wr_n;
      wr_prev <= wr_q;
      rd_q    <= rd_n;
      rs_q    <= rs;
      rst_n_q <= reset_n;
      data_q  <= data;
    end
  end

  // Keep RS/Data from the most recent cycle with Wr_n low; valid on the rise.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      cap_rs   <= 1'b0;
      cap_data <= '0;
    end else if (!wr_q) begin
      cap_rs   <= rs_q;
      cap_data <= data_q;
    end
  end

  assign wr.wr_event = !wr_prev && wr_q && !cs_q;
  assign wr.is_data  = cap_rs;
  assign wr.word     = cap_data;
  assign conflict    = !cs_q && !wr_q && !rd_q;
  assign panel_rst   = !rst_n_q;

`ifdef LT24_TIMING_CHECK_EN
  localparam int CW = $clog2(MIN_WR_LOW + 1) + 1;
  logic [CW-1:0] low_cnt;

  // Saturating count of CS-qualified Wr_n low cycles; cleared while Wr_n high.
  always_ff @(posedge clock) begin
    if (globalReset || wr_q) low_cnt <= '0;
    else if (!cs_q && low_cnt != '1) low_cnt <= low_cnt + 1'b1;
  end

  assign short_wr = wr.wr_event && (low_cnt < CW'(MIN_WR_LOW));
`else
  assign short_wr = 1'b0;
`endif

endmodule

// File: rtl/lt24_bus_decoder.sv
// LT24 8080-style write bus decoder: command decode, column/page window
// setup and per-word pixel events with window-wrapping cursor.
// Optional pulse-width check is enabled with LT24_TIMING_CHECK_EN.
module lt24_bus_decoder
  import lt24_pkg::*;
#(
  parameter int WIDTH      = LT24_WIDTH,
  parameter int HEIGHT     = LT24_HEIGHT,
  parameter int MIN_WR_LOW = 2
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic        LT24CS_n,
  input  logic        LT24Wr_n,
  input  logic        LT24Rd_n,
  input  logic        LT24RS,
  input  logic        LT24Reset_n,
  input  logic [15:0] LT24Data,
  output logic        cmdValid,
  output logic [7:0]  cmdCode,
  output logic        pixelValid,
  output logic [7:0]  pixelX,
  output logic [8:0]  pixelY,
  output logic [15:0] pixelColour,
  output logic        protocolError
);

  localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
  localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);

  lt24_wr_t wr;
  logic     conflict, short_wr, panel_rst;

  lt24_write_strobe #(.MIN_WR_LOW(MIN_WR_LOW)) u_strobe (
    .clock      (clock),
    .globalReset(globalReset),
    .cs_n       (LT24CS_n),
    .wr_n       (LT24Wr_n),
    .rd_n       (LT24Rd_n),
    .rs         (LT24RS),
    .reset_n    (LT24Reset_n),
    .data       (LT24Data),
    .wr         (wr),
    .conflict   (conflict),
    .short_wr   (short_wr),
    .panel_rst  (panel_rst)
  );

  lt24_state_t state, state_n;
  logic [1:0]  arg_idx, arg_idx_n;
  logic [7:0]  b0, b1, b2, b0_n, b1_n, b2_n;
  logic [15:0] sc, ec, sp, ep, sc_n, ec_n, sp_n, ep_n;
  logic [7:0]  cur_x, cur_x_n;
  logic [8:0]  cur_y, cur_y_n;
  logic        cmd_valid_n, pix_valid_n, err_n;
  logic [7:0]  cmd_code_n, pix_x_n;
  logic [8:0]  pix_y_n;
  logic [15:0] colour_n;
  logic [15:0] new_s, new_e;
  logic        win_ok;

  assign win_ok = (sc <= ec) && (ec <= X_MAX) && (sp <= ep) && (ep <= Y_MAX);
  assign new_s  = {b0, b1};
  assign new_e  = {b2, wr.word[7:0]};

  // State and datapath register bank.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      state         <= IDLE;
      arg_idx       <= '0;
      b0            <= '0;
      b1            <= '0;
      b2            <= '0;
      sc            <= '0;
      ec            <= X_MAX;
      sp            <= '0;
      ep            <= Y_MAX;
      cur_x         <= '0;
      cur_y         <= '0;
      cmdValid      <= 1'b0;
      cmdCode       <= '0;
      pixelValid    <= 1'b0;
      pixelX        <= '0;
      pixelY        <= '0;
      pixelColour   <= '0;
      protocolError <= 1'b0;
    end else begin
      state         <= state_n;
      arg_idx       <= arg_idx_n;
      b0            <= b0_n;
      b1            <= b1_n;
      b2            <= b2_n;
      sc            <= sc_n;
      ec            <= ec_n;
      sp            <= sp_n;
      ep            <= ep_n;
      cur_x         <= cur_x_n;
      cur_y         <= cur_y_n;
      cmdValid      <= cmd_valid_n;
      cmdCode       <= cmd_code_n;
      pixelValid    <= pix_valid_n;
      pixelX        <= pix_x_n;
      pixelY        <= pix_y_n;
      pixelColour   <= colour_n;
      protocolError <= err_n;
    end
  end

  // Next-state: command decode, argument collection, pixel cursor, errors.
  always_comb begin
    state_n     = state;
    arg_idx_n   = arg_idx;
    b0_n        = b0;
    b1_n        = b1;
    b2_n        = b2;
    sc_n        = sc;
    ec_n        = ec;
    sp_n        = sp;
    ep_n        = ep;
    cur_x_n     = cur_x;
    cur_y_n     = cur_y;
    cmd_valid_n = 1'b0;
    cmd_code_n  = cmdCode;
    pix_valid_n = 1'b0;
    pix_x_n     = pixelX;
    pix_y_n     = pixelY;
    colour_n    = pixelColour;
    err_n       = protocolError || conflict || short_wr;

    if (panel_rst) begin
      state_n   = IDLE;
      arg_idx_n = '0;
      sc_n      = '0;
      ec_n      = X_MAX;
      sp_n      = '0;
      ep_n      = Y_MAX;
    end else if (wr.wr_event) begin
      if (!wr.is_data) begin
        // Commands always win; collected argument bytes are simply dropped.
        cmd_valid_n = 1'b1;
        cmd_code_n  = wr.word[7:0];
        arg_idx_n   = '0;
        case (wr.word[7:0])
          CMD_COL_ADDR:  state_n = COL_ARGS;
          CMD_PAGE_ADDR: state_n = PAGE_ARGS;
          CMD_MEM_WRITE: begin
            state_n = MEM_WRITE;
            cur_x_n = sc[7:0];
            cur_y_n = sp[8:0];
          end
          default:       state_n = SKIP;
        endcase
      end else begin
        case (state)
          COL_ARGS, PAGE_ARGS: begin
            arg_idx_n = arg_idx + 2'd1;
            case (arg_idx)
              2'd0: b0_n = wr.word[7:0];
              2'd1: b1_n = wr.word[7:0];
              2'd2: b2_n = wr.word[7:0];
              default: begin
                // Start and end commit together; a bad window is still stored.
                state_n = IDLE;
                if (state == COL_ARGS) begin
                  sc_n = new_s;
                  ec_n = new_e;
                  if (new_s > new_e || new_e > X_MAX) err_n = 1'b1;
                end else begin
                  sp_n = new_s;
                  ep_n = new_e;
                  if (new_s > new_e || new_e > Y_MAX) err_n = 1'b1;
                end
              end
            endcase
          end
          MEM_WRITE: begin
            if (win_ok) begin
              pix_valid_n = 1'b1;
              pix_x_n     = cur_x;
              pix_y_n     = cur_y;
              colour_n    = wr.word;
              if ({8'd0, cur_x} == ec) begin
                cur_x_n = sc[7:0];
                cur_y_n = ({7'd0, cur_y} == ep) ? sp[8:0] : cur_y + 9'd1;
              end else begin
                cur_x_n = cur_x + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Self-checking bench for lt24_bus_decoder: table-driven directed vectors,
// hand-written corner sequences and a randomized window/pixel run checked
// against a linear-index pixel model.
module tb_lt24_bus_decoder;

  logic        clock = 1'b0;
  logic        globalReset;
  logic        LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS, LT24Reset_n;
  logic [15:0] LT24Data;
  logic        cmdValid, pixelValid, protocolError;
  logic [7:0]  cmdCode, pixelX;
  logic [8:0]  pixelY;
  logic [15:0] pixelColour;

  int n_vec = 0;
  int n_bad = 0;

  lt24_bus_decoder dut (
    .clock        (clock),
    .globalReset  (globalReset),
    .LT24CS_n     (LT24CS_n),
    .LT24Wr_n     (LT24Wr_n),
    .LT24Rd_n     (LT24Rd_n),
    .LT24RS       (LT24RS),
    .LT24Reset_n  (LT24Reset_n),
    .LT24Data     (LT24Data),
    .cmdValid     (cmdValid),
    .cmdCode      (cmdCode),
    .pixelValid   (pixelValid),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .pixelColour  (pixelColour),
    .protocolError(protocolError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rs;
    logic [15:0] data;
    logic        exp_cmd;
    logic        exp_pv;
    int          exp_x;
    int          exp_y;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic [15:0] d, logic c, logic p, int x, int y);
    vec_t v;
    v.rs = rs; v.data = d; v.exp_cmd = c; v.exp_pv = p; v.exp_x = x; v.exp_y = y;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus write starting on a negedge; samples 1 and 2 clocks after the rise.
  task automatic bus_wr(input logic rs, input logic [15:0] d, input int low, input logic cs,
                        output logic early, output logic pv, output logic cv);
    LT24CS_n = cs; LT24RS = rs; LT24Data = d; LT24Wr_n = 1'b0;
    repeat (low) @(negedge clock);
    LT24Wr_n = 1'b1;
    @(negedge clock);
    early = pixelValid | cmdValid;
    @(negedge clock);
    pv = pixelValid;
    cv = cmdValid;
  endtask

  task automatic do_reset();
    globalReset = 1'b1;
    LT24CS_n = 1'b1; LT24Wr_n = 1'b1; LT24Rd_n = 1'b1; LT24RS = 1'b0;
    LT24Reset_n = 1'b1; LT24Data = '0;
    repeat (3) @(negedge clock);
    globalReset = 1'b0;
    @(negedge clock);
  endtask

  logic e, pv, cv;

  // Window command with 4 argument words; random junk in the unused high byte.
  task automatic set_win(input logic [7:0] cmd, input int s, input int en);
    bus_wr(1'b0, {8'h00, cmd}, 2, 1'b0, e, pv, cv);
    bus_wr(1'b1, {8'($urandom), 8'(s >> 8)}, 2, 1'b0, e, pv, cv);
    bus_wr(1'b1, {8'($urandom), 8'(s)},      2, 1'b0, e, pv, cv);
    bus_wr(1'b1, {8'($urandom), 8'(en >> 8)}, 2, 1'b0, e, pv, cv);
    bus_wr(1'b1, {8'($urandom), 8'(en)},      2, 1'b0, e, pv, cv);
  endtask

  initial begin
    do_reset();

    // Reset state
    chk("rst_cmdValid", 32'(cmdValid), 0);
    chk("rst_cmdCode", 32'(cmdCode), 0);
    chk("rst_pixelValid", 32'(pixelValid), 0);
    chk("rst_pixelX", 32'(pixelX), 0);
    chk("rst_pixelY", 32'(pixelY), 0);
    chk("rst_colour", 32'(pixelColour), 0);
    chk("rst_err", 32'(protocolError), 0);

    // Directed table: basic writes, window setup with wrap, aborted args, SKIP.
    tbl.push_back(mk(0, 16'h002C, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'hAAAA, 0, 1, 0, 0));
    tbl.push_back(mk(1, 16'hBBBB, 0, 1, 1, 0));
    tbl.push_back(mk(1, 16'hCCCC, 0, 1, 2, 0));
    tbl.push_back(mk(0, 16'h002A, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h5500, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'hAB0A, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h000B, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h002B, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0006, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h002C, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h1111, 0, 1, 10, 5));
    tbl.push_back(mk(1, 16'h2222, 0, 1, 11, 5));
    tbl.push_back(mk(1, 16'h3333, 0, 1, 10, 6));
    tbl.push_back(mk(1, 16'h4444, 0, 1, 11, 6));
    tbl.push_back(mk(1, 16'h5555, 0, 1, 10, 5));
    tbl.push_back(mk(0, 16'h002A, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0003, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h002C, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h6666, 0, 1, 10, 5));
    tbl.push_back(mk(0, 16'h0011, 1, 0, 0, 0));
    tbl.push_back(mk(1, 16'h7777, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      bus_wr(tbl[i].rs, tbl[i].data, 2, 1'b0, e, pv, cv);
      chk($sformatf("t%0d_early", i), 32'(e), 0);
      chk($sformatf("t%0d_cmdValid", i), 32'(cv), 32'(tbl[i].exp_cmd));
      chk($sformatf("t%0d_pixelValid", i), 32'(pv), 32'(tbl[i].exp_pv));
      if (tbl[i].exp_cmd) chk($sformatf("t%0d_cmdCode", i), 32'(cmdCode), 32'(tbl[i].data[7:0]));
      if (tbl[i].exp_pv) begin
        chk($sformatf("t%0d_x", i), 32'(pixelX), 32'(tbl[i].exp_x));
        chk($sformatf("t%0d_y", i), 32'(pixelY), 32'(tbl[i].exp_y));
        chk($sformatf("t%0d_colour", i), 32'(pixelColour), 32'(tbl[i].data));
      end
      chk($sformatf("t%0d_err", i), 32'(protocolError), 0);
    end

    // Randomized legal windows against a linear-index model.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      int sc, ec, sp, ep, npx, w, h;
      logic [15:0] col;
      sc = $urandom_range(0, 239); ec = sc + $urandom_range(0, 4); if (ec > 239) ec = 239;
      sp = $urandom_range(0, 319); ep = sp + $urandom_range(0, 3); if (ep > 319) ep = 319;
      set_win(8'h2A, sc, ec);
      set_win(8'h2B, sp, ep);
      bus_wr(1'b0, 16'h002C, 2, 1'b0, e, pv, cv);
      chk("rnd_cmd", 32'(cv), 1);
      w = ec - sc + 1; h = ep - sp + 1;
      npx = $urandom_range(1, 12);
      for (int k = 0; k < npx; k++) begin
        col = 16'($urandom);
        bus_wr(1'b1, col, $urandom_range(2, 3), 1'b0, e, pv, cv);
        chk("rnd_pv", 32'(pv), 1);
        chk("rnd_x", 32'(pixelX), 32'(sc + k % w));
        chk("rnd_y", 32'(pixelY), 32'(sp + (k / w) % h));
        chk("rnd_colour", 32'(pixelColour), 32'(col));
      end
      if (r % 3 == 2) begin
        bus_wr(1'b0, {8'h00, 8'($urandom_range(0, 8'h29))}, 2, 1'b0, e, pv, cv);
        bus_wr(1'b1, 16'($urandom), 2, 1'b0, e, pv, cv);
        chk("rnd_skip_pv", 32'(pv), 0);
      end
    end
    chk("rnd_err", 32'(protocolError), 0);

    // Invalid window: error, no pixels, flag survives panel reset.
    do_reset();
    set_win(8'h2A, 16'h000A, 16'h0005);
    chk("badwin_err", 32'(protocolError), 1);
    bus_wr(1'b0, 16'h002C, 2, 1'b0, e, pv, cv);
    bus_wr(1'b1, 16'h1234, 2, 1'b0, e, pv, cv);
    chk("badwin_no_pixel", 32'(pv), 0);
    LT24Reset_n = 1'b0;
    repeat (2) @(negedge clock);
    LT24Reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("panelrst_err_kept", 32'(protocolError), 1);
    bus_wr(1'b0, 16'h002C, 2, 1'b0, e, pv, cv);
    bus_wr(1'b1, 16'h4321, 2, 1'b0, e, pv, cv);
    chk("panelrst_pv", 32'(pv), 1);
    chk("panelrst_x", 32'(pixelX), 0);
    chk("panelrst_y", 32'(pixelY), 0);

    // Strobes without chip select are ignored; Rd/Wr conflict flags an error.
    do_reset();
    chk("glbrst_err_clear", 32'(protocolError), 0);
    bus_wr(1'b0, 16'h002C, 2, 1'b0, e, pv, cv);
    bus_wr(1'b1, 16'h0F0F, 2, 1'b1, e, pv, cv);
    chk("nocs_pv", 32'(pv), 0);
    bus_wr(1'b0, 16'h002A, 2, 1'b1, e, pv, cv);
    chk("nocs_cmd", 32'(cv), 0);
    chk("nocs_err", 32'(protocolError), 0);
    LT24CS_n = 1'b0; LT24RS = 1'b1; LT24Rd_n = 1'b0; LT24Wr_n = 1'b0;
    repeat (2) @(negedge clock);
    LT24Wr_n = 1'b1; LT24Rd_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("conflict_err", 32'(protocolError), 1);

    // Strobe pulse width: 2-clock low is clean, 1-clock low is flagged if checked.
    do_reset();
    bus_wr(1'b0, 16'h002C, 2, 1'b0, e, pv, cv);
    bus_wr(1'b1, 16'hBEEF, 2, 1'b0, e, pv, cv);
    chk("wide_pv", 32'(pv), 1);
    chk("wide_err", 32'(protocolError), 0);
    bus_wr(1'b1, 16'hCAFE, 1, 1'b0, e, pv, cv);
    chk("short_pv", 32'(pv), 1);
    chk("short_colour", 32'(pixelColour), 32'(16'hCAFE));
`ifdef LT24_TIMING_CHECK_EN
    chk("short_err", 32'(protocolError), 1);
`else
    chk("short_err", 32'(protocolError), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
